// File: rtl/cnn_mem_pkg.sv
// Shared types and constants for the CNN OBI subordinate memory.
// - OBI configuration record and the default OBI request/response structs
//   (no rready; r_optional is a single reserved bit).
// - rsp_stage_t: one slot of the response pipeline.
// - ERR_PATTERN: read data returned for erroneous accesses.
// - MaxLatency: deepest response pipeline supported.
// - CNT_W: width of the saturating access counters.
package cnn_mem_pkg;

  localparam int unsigned MaxLatency = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ID_W       = 4;

  localparam logic [DATA_W-1:0] ERR_PATTERN = 32'hBADC_AB1E;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: ADDR_W,
    DataWidth: DATA_W,
    IdWidth:   ID_W
  };

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic [ID_W-1:0]   aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic              err;
    logic              r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_stage_t;

endpackage

// File: rtl/cnn_rsp_pipe.sv
// Fixed-depth response pipeline for the OBI subordinate memory.
// A response pushed in cycle N appears on stage_o in cycle N+Depth for one
// cycle. Only the valid bits are reset; payload flops are free-running.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         load a new response into the first stage
//   stage_i        response payload to load (valid field ignored)
//   stage_o        last stage; valid field reflects the reset valid bit
//   busy_o         any stage holds a valid response
module cnn_rsp_pipe
  import cnn_mem_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  rsp_stage_t stage_i,
  output rsp_stage_t stage_o,
  output logic       busy_o
);

  logic [Depth-1:0] valid_d, valid_q;
  rsp_stage_t       data_d [Depth];
  rsp_stage_t       data_q [Depth];

  always_comb begin
    valid_d[0] = push_i;
    data_d[0]  = stage_i;
    for (int i = 1; i < Depth; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  always_comb begin
    stage_o       = data_q[Depth-1];
    stage_o.valid = valid_q[Depth-1];
  end

  assign busy_o = |valid_q;

endmodule

// File: rtl/cnn_obi_mem_sbr.sv
// OBI subordinate word memory for the CNN accelerator's manager port.
// Grants combinationally unless stalled, decodes the word address, performs
// byte-enabled writes at the acceptance edge and returns one response per
// accepted request exactly Latency cycles later, in acceptance order.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   sbr_obi_req_i   OBI request (req, a.addr/we/be/wdata/aid)
//   sbr_obi_rsp_o   OBI response (gnt, rvalid, r.rdata/rid/err)
//   stall_i         holds gnt low while high
//   busy_o          at least one response in flight
//   rd_cnt_o        accepted good reads, saturating
//   wr_cnt_o        accepted good writes, saturating
//   err_cnt_o       accepted erroneous accesses, saturating
module cnn_obi_mem_sbr
  import cnn_mem_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg    = cnn_mem_pkg::ObiDefaultConfig,
  parameter type         obi_req_t = cnn_mem_pkg::obi_req_t,
  parameter type         obi_rsp_t = cnn_mem_pkg::obi_rsp_t,
  parameter int unsigned NumWords  = 1024,
  parameter logic [31:0] BaseAddr  = 32'h1A10_0000,
  parameter int unsigned Latency   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  obi_req_t         sbr_obi_req_i,
  output obi_rsp_t         sbr_obi_rsp_o,
  input  logic             stall_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned IdxW     = $clog2(NumWords);
  localparam logic [31:0] MemBytes = 32'(NumWords * 4);

  if (Latency < 1 || Latency > MaxLatency) begin : g_bad_latency
    $error("cnn_obi_mem_sbr: Latency must be 1..4");
  end
  if (NumWords != (1 << IdxW)) begin : g_bad_words
    $error("cnn_obi_mem_sbr: NumWords must be a power of two");
  end
  if (ObiCfg.AddrWidth != ADDR_W || ObiCfg.DataWidth != DATA_W ||
      ObiCfg.IdWidth != ID_W) begin : g_bad_cfg
    $error("cnn_obi_mem_sbr: OBI config does not match the struct widths");
  end

  logic            gnt, acc;
  logic [31:0]     off;
  logic            dec_err;
  logic [IdxW-1:0] idx;
  logic [31:0]     mem_q [NumWords];
  rsp_stage_t      stage_in, stage_out;

  logic [CNT_W-1:0] rd_cnt_d, rd_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d, wr_cnt_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

  assign gnt = sbr_obi_req_i.req & ~stall_i;
  assign acc = sbr_obi_req_i.req & gnt;

  // Offset wraps for addresses below the base; the explicit compare catches it.
  assign off     = sbr_obi_req_i.a.addr - BaseAddr;
  assign dec_err = (sbr_obi_req_i.a.addr < BaseAddr) | (off >= MemBytes) |
                   (sbr_obi_req_i.a.addr[1:0] != 2'b00);
  assign idx     = off[IdxW+1:2];

  // Array is deliberately not reset so it survives a mid-operation reset.
  always_ff @(posedge clk_i) begin
    if (acc && sbr_obi_req_i.a.we && !dec_err) begin
      for (int k = 0; k < 4; k++) begin
        if (sbr_obi_req_i.a.be[k]) begin
          mem_q[idx][8*k +: 8] <= sbr_obi_req_i.a.wdata[8*k +: 8];
        end
      end
    end
  end

  // Read data is captured in the acceptance cycle, before that edge's write.
  always_comb begin
    stage_in       = '0;
    stage_in.valid = acc;
    stage_in.id    = sbr_obi_req_i.a.aid;
    stage_in.err   = dec_err;
    if (dec_err) begin
      stage_in.rdata = ERR_PATTERN;
    end else if (!sbr_obi_req_i.a.we) begin
      stage_in.rdata = mem_q[idx];
    end
  end

  cnn_rsp_pipe #(
    .Depth(Latency)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (acc),
    .stage_i(stage_in),
    .stage_o(stage_out),
    .busy_o (busy_o)
  );

  // Response fields are forced to zero whenever no response is due.
  always_comb begin
    sbr_obi_rsp_o              = '0;
    sbr_obi_rsp_o.gnt          = gnt;
    sbr_obi_rsp_o.rvalid       = stage_out.valid;
    sbr_obi_rsp_o.r.r_optional = 1'b0;
    if (stage_out.valid) begin
      sbr_obi_rsp_o.r.rdata = stage_out.rdata;
      sbr_obi_rsp_o.r.rid   = stage_out.id;
      sbr_obi_rsp_o.r.err   = stage_out.err;
    end
  end

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (acc) begin
      if (dec_err) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end else if (sbr_obi_req_i.a.we) begin
        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
      end else begin
        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_cnn_obi_mem_sbr.sv
// Directed bench for cnn_obi_mem_sbr with Latency = 3.
// The driver pushes each expected response (due cycle, id, err, rdata) into
// exp_q when it sees the grant; the monitor pops and compares on rvalid.
module tb_cnn_obi_mem_sbr;
  import cnn_mem_pkg::*;

  localparam int unsigned LAT  = 3;
  localparam int unsigned NW   = 1024;
  localparam logic [31:0] BASE = 32'h1A10_0000;
  localparam int unsigned W    = 69;  // {due_cyc[31:0], id[3:0], err, rdata[31:0]}

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  obi_req_t         req;
  obi_rsp_t         rsp;
  logic             stall;
  logic             busy;
  logic [CNT_W-1:0] rd_cnt, wr_cnt, err_cnt;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_rd = 0, exp_wr = 0, exp_err = 0;
  logic [W-1:0] exp_q[$];

  cnn_obi_mem_sbr #(
    .NumWords(NW),
    .BaseAddr(BASE),
    .Latency (LAT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .sbr_obi_req_i(req),
    .sbr_obi_rsp_o(rsp),
    .stall_i      (stall),
    .busy_o       (busy),
    .rd_cnt_o     (rd_cnt),
    .wr_cnt_o     (wr_cnt),
    .err_cnt_o    (err_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic [3:0] id, input logic [31:0] exp_rdata,
                       input logic exp_e);
    bit done = 0;
    @(negedge clk);
    req.req     = 1'b1;
    req.a.we    = we;
    req.a.addr  = addr;
    req.a.be    = be;
    req.a.wdata = wdata;
    req.a.aid   = id;
    #1;
    for (int t = 0; t < 20 && !done; t++) begin
      if (rsp.gnt === 1'b1) begin
        exp_q.push_back({32'(cyc + LAT), id, exp_e, exp_rdata});
        if (exp_e) exp_err++;
        else if (we) exp_wr++;
        else exp_rd++;
        done = 1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: got no gnt expected gnt for id %0d", id);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req.req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_ni) begin
      check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      if (rsp.rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rvalid: got rvalid=1 rid=%0d expected none (cycle %0d)",
                   rsp.r.rid, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", cyc, e[68:37]);
          check("rid", {28'd0, rsp.r.rid}, {28'd0, e[36:33]});
          check("err", {31'd0, rsp.r.err}, {31'd0, e[32]});
          check("rdata", rsp.r.rdata, e[31:0]);
        end
      end else begin
        check("rvalid_known", {31'd0, rsp.rvalid}, 32'd0);
        check("idle_rdata", rsp.r.rdata, 32'd0);
        check("idle_rid", {28'd0, rsp.r.rid}, 32'd0);
        check("idle_err", {31'd0, rsp.r.err}, 32'd0);
        if (exp_q.size() != 0 && exp_q[0][68:37] <= cyc) begin
          e = exp_q.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missing_rvalid: got none expected rid %0d at cycle %0d",
                   e[36:33], e[68:37]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd_before;
    req   = '0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rvalid", {31'd0, rsp.rvalid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rd_cnt", {16'd0, rd_cnt}, 32'd0);
    check("reset_wr_cnt", {16'd0, wr_cnt}, 32'd0);
    check("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
    rst_ni = 1'b1;

    // Full-word write and read-back of word 0
    issue(1'b1, BASE, 4'hF, 32'hDEAD_BEEF, 4'd1, 32'h0, 1'b0);
    issue(1'b0, BASE, 4'hF, 32'h0, 4'd2, 32'hDEAD_BEEF, 1'b0);
    idle();
    drain();

    // Partial byte write, read in the very next cycle
    issue(1'b1, BASE + 32'd4, 4'hF, 32'h1122_3344, 4'd3, 32'h0, 1'b0);
    issue(1'b1, BASE + 32'd4, 4'b0101, 32'hAABB_CCDD, 4'd4, 32'h0, 1'b0);
    issue(1'b0, BASE + 32'd4, 4'hF, 32'h0, 4'd5, 32'h11BB_33DD, 1'b0);
    // be = 0 leaves the word unchanged
    issue(1'b1, BASE + 32'd4, 4'h0, 32'hFFFF_FFFF, 4'd6, 32'h0, 1'b0);
    issue(1'b0, BASE + 32'd4, 4'hF, 32'h0, 4'd7, 32'h11BB_33DD, 1'b0);
    // Last word of the array
    issue(1'b1, BASE + 32'd4092, 4'hF, 32'hCAFE_F00D, 4'd8, 32'h0, 1'b0);
    issue(1'b0, BASE + 32'd4092, 4'hF, 32'h0, 4'd9, 32'hCAFE_F00D, 1'b0);
    idle();
    drain();

    // Out of range and misaligned reads
    rd_before = {16'd0, rd_cnt};
    issue(1'b0, BASE + 32'd4096, 4'hF, 32'h0, 4'd10, 32'hBADC_AB1E, 1'b1);
    issue(1'b0, BASE + 32'd2, 4'hF, 32'h0, 4'd11, 32'hBADC_AB1E, 1'b1);
    idle();
    drain();
    check("err_cnt_after_two", {16'd0, err_cnt}, 32'd2);
    check("rd_cnt_unchanged", {16'd0, rd_cnt}, rd_before);
    // Write below the base address is also an error
    issue(1'b1, BASE - 32'd4, 4'hF, 32'h1234_5678, 4'd12, 32'hBADC_AB1E, 1'b1);
    idle();
    drain();
    check("err_cnt", {16'd0, err_cnt}, 32'(exp_err));
    check("wr_cnt", {16'd0, wr_cnt}, 32'(exp_wr));

    // Back-to-back: fill words 2..7, then 8 reads ids 0..7 on consecutive cycles
    for (int i = 2; i < 8; i++)
      issue(1'b1, BASE + 32'(4 * i), 4'hF, 32'hA500_0000 | 32'(i), 4'(i), 32'h0, 1'b0);
    issue(1'b0, BASE, 4'hF, 32'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, BASE + 32'd4, 4'hF, 32'h0, 4'd1, 32'h11BB_33DD, 1'b0);
    for (int i = 2; i < 8; i++)
      issue(1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, 4'(i), 32'hA500_0000 | 32'(i), 1'b0);
    idle();
    drain();
    check("rd_cnt", {16'd0, rd_cnt}, 32'(exp_rd));

    // Stall with request held for 5 cycles
    @(negedge clk);
    req.req    = 1'b1;
    req.a.we   = 1'b0;
    req.a.addr = BASE;
    req.a.be   = 4'hF;
    req.a.aid  = 4'd9;
    stall      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_gnt_low", {31'd0, rsp.gnt}, 32'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    check("stall_release_gnt", {31'd0, rsp.gnt}, 32'd1);
    exp_q.push_back({32'(cyc + LAT), 4'd9, 1'b0, 32'hDEAD_BEEF});
    exp_rd++;
    idle();
    drain();

    // Reset with two responses in flight
    issue(1'b0, BASE, 4'hF, 32'h0, 4'd1, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, BASE + 32'd4, 4'hF, 32'h0, 4'd2, 32'h11BB_33DD, 1'b0);
    @(negedge clk);
    #3;
    req.req = 1'b0;
    rst_ni  = 1'b0;
    exp_q.delete();
    exp_rd  = 0;
    exp_wr  = 0;
    exp_err = 0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rvalid", {31'd0, rsp.rvalid}, 32'd0);
    #3;
    rst_ni = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
    check("post_rst_wr_cnt", {16'd0, wr_cnt}, 32'd0);
    check("post_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    issue(1'b0, BASE, 4'hF, 32'h0, 4'd3, 32'hDEAD_BEEF, 1'b0);
    idle();
    drain();
    check("final_rd_cnt", {16'd0, rd_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
